rca_chunk_serial_adder: RTL and testbench



---
 rtl/rca_chunk_serial_adder_if.sv | 33 +++
 rtl/rca_chunk_serial_adder.sv | 106 ++++++++++
 tb/tb_rca_chunk_serial_adder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rca_chunk_serial_adder_if.sv
// Handshake and data bus for the chunk-serial ripple-carry adder.
// The ovf signal exists only when RCA_SIGNED_OVF_EN is defined.
interface rca_chunk_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef RCA_SIGNED_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
`ifdef RCA_SIGNED_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
`ifdef RCA_SIGNED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/rca_chunk_serial_adder.sv
// Multi-cycle adder: one CHUNK-bit ripple slice, LSB chunk first, carry held between chunks.
// Optional signed-overflow flag enabled by defining RCA_SIGNED_OVF_EN.
module rca_chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    rca_chunk_serial_adder_if.slave    bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("rca_chunk_serial_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;
    logic [CHUNK:0]    chunk_sum;
    logic              last_chunk;

    assign a_chunk    = a_reg[int'(cnt)*CHUNK +: CHUNK];
    assign b_chunk    = b_reg[int'(cnt)*CHUNK +: CHUNK];
    assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    assign last_chunk = (cnt == CW'(N - 1));

`ifdef RCA_SIGNED_OVF_EN
    logic ovf_reg;
    logic msb_cin;

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    assign bus.ovf = ovf_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef RCA_SIGNED_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (state != RUN) begin
                // IDLE and DONE both accept a new request, which allows back-to-back operation.
                if (bus.start) begin
                    a_reg    <= bus.a;
                    b_reg    <= bus.b;
                    carry    <= bus.cin;
                    cnt      <= '0;
                    sum_reg  <= '0;
                    cout_reg <= 1'b0;
                    busy_reg <= 1'b1;
                    state    <= RUN;
`ifdef RCA_SIGNED_OVF_EN
                    ovf_reg  <= 1'b0;
`endif
                end else begin
                    state <= IDLE;
                end
            end else begin
                sum_reg[int'(cnt)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                carry <= chunk_sum[CHUNK];
                if (last_chunk) begin
                    cout_reg <= chunk_sum[CHUNK];
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    state    <= DONE;
`ifdef RCA_SIGNED_OVF_EN
                    ovf_reg  <= msb_cin ^ chunk_sum[CHUNK];
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
endmodule

// File: tb/tb_rca_chunk_serial_adder.sv
// Directed bench for rca_chunk_serial_adder across four WIDTH/CHUNK configurations.
// Define RCA_SIGNED_OVF_EN for both RTL and bench to also check the overflow flag.
module tb_rca_chunk_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rca_chunk_serial_adder_if #(.WIDTH(8))  bus84 ();
    rca_chunk_serial_adder_if #(.WIDTH(16)) bus161 ();
    rca_chunk_serial_adder_if #(.WIDTH(8))  bus82 ();
    rca_chunk_serial_adder_if #(.WIDTH(8))  bus88 ();

    rca_chunk_serial_adder #(.WIDTH(8),  .CHUNK(4)) dut84  (.clk(clk), .rst_n(rst_n), .bus(bus84.slave));
    rca_chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) dut161 (.clk(clk), .rst_n(rst_n), .bus(bus161.slave));
    rca_chunk_serial_adder #(.WIDTH(8),  .CHUNK(2)) dut82  (.clk(clk), .rst_n(rst_n), .bus(bus82.slave));
    rca_chunk_serial_adder #(.WIDTH(8),  .CHUNK(8)) dut88  (.clk(clk), .rst_n(rst_n), .bus(bus88.slave));

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // sel: 0 = 8/4, 1 = 16/1, 2 = 8/2, 3 = 8/8
    task automatic applyStimulus(input int sel, input logic s, input logic [15:0] av,
                                 input logic [15:0] bv, input logic c);
        case (sel)
            0: begin bus84.start = s;  bus84.a = av[7:0];  bus84.b = bv[7:0];  bus84.cin = c;  end
            1: begin bus161.start = s; bus161.a = av;      bus161.b = bv;      bus161.cin = c; end
            2: begin bus82.start = s;  bus82.a = av[7:0];  bus82.b = bv[7:0];  bus82.cin = c;  end
            default: begin bus88.start = s; bus88.a = av[7:0]; bus88.b = bv[7:0]; bus88.cin = c; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int done_seen;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rsum;

        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) applyStimulus(s, 1'b0, 16'h0, 16'h0, 1'b0);
        #12;
        checkOutput("rst_busy", bus84.busy, 1'b0);
        checkOutput("rst_done", bus84.done, 1'b0);
        checkOutput("rst_sum",  bus84.sum,  8'h00);
        checkOutput("rst_cout", bus84.cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 8/4: 0x00 + 0x01
        applyStimulus(0, 1'b1, 16'h00, 16'h01, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 16'h00, 16'h01, 1'b0);
        checkOutput("t1_busy_c1", bus84.busy, 1'b1);
        checkOutput("t1_done_c1", bus84.done, 1'b0);
        tick();
        checkOutput("t1_busy_c2", bus84.busy, 1'b1);
        tick();
        checkOutput("t1_busy_end", bus84.busy, 1'b0);
        checkOutput("t1_done",     bus84.done, 1'b1);
        checkOutput("t1_sum",      bus84.sum,  8'h01);
        checkOutput("t1_cout",     bus84.cout, 1'b0);
`ifdef RCA_SIGNED_OVF_EN
        checkOutput("t1_ovf",      bus84.ovf,  1'b0);
`endif
        tick();
        checkOutput("t1_done_pulse", bus84.done, 1'b0);
        checkOutput("t1_sum_hold",   bus84.sum,  8'h01);

        // 8/4: 0x77 + 0x55, then back-to-back 0x8C + 0x74
        applyStimulus(0, 1'b1, 16'h77, 16'h55, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 16'hFF, 16'hFF, 1'b1);
        checkOutput("t2_sum_clear", bus84.sum, 8'h00);
        tick();
        checkOutput("t2_sum_partial", bus84.sum, 8'h0C);
        tick();
        checkOutput("t2_done", bus84.done, 1'b1);
        checkOutput("t2_sum",  bus84.sum,  8'hCC);
        checkOutput("t2_cout", bus84.cout, 1'b0);
`ifdef RCA_SIGNED_OVF_EN
        checkOutput("t2_ovf",  bus84.ovf,  1'b1);
`endif
        applyStimulus(0, 1'b1, 16'h8C, 16'h74, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 16'h00, 16'h00, 1'b0);
        checkOutput("t2b_busy",     bus84.busy, 1'b1);
        checkOutput("t2b_sum_clr",  bus84.sum,  8'h00);
        checkOutput("t2b_cout_clr", bus84.cout, 1'b0);
        tick();
        tick();
        checkOutput("t2b_done", bus84.done, 1'b1);
        checkOutput("t2b_sum",  bus84.sum,  8'h00);
        checkOutput("t2b_cout", bus84.cout, 1'b1);
`ifdef RCA_SIGNED_OVF_EN
        checkOutput("t2b_ovf",  bus84.ovf,  1'b0);
`endif
        tick();

        // 16/1: 0xFFFF + 0x0000 + 1, start pulsed mid-run
        applyStimulus(1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        applyStimulus(1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        cycles = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) applyStimulus(1, 1'b1, 16'h1234, 16'h1111, 1'b0);
            tick();
            if (i == 5) begin
                checkOutput("t3_busy_c5", bus161.busy, 1'b1);
                applyStimulus(1, 1'b0, 16'h1234, 16'h1111, 1'b0);
            end
            if (bus161.done) begin
                cycles = i;
                break;
            end
        end
        checkOutput("t3_latency", cycles, 16);
        checkOutput("t3_sum",     bus161.sum,  16'h0000);
        checkOutput("t3_cout",    bus161.cout, 1'b1);
        tick();
        checkOutput("t3_no_queue_busy", bus161.busy, 1'b0);
        checkOutput("t3_no_queue_done", bus161.done, 1'b0);

        // 8/2: asynchronous reset mid-operation
        applyStimulus(2, 1'b1, 16'hAA, 16'h55, 1'b0);
        tick();
        applyStimulus(2, 1'b0, 16'hAA, 16'h55, 1'b0);
        tick();
        tick();
        checkOutput("t4_busy_pre", bus82.busy, 1'b1);
        checkOutput("t4_sum_pre",  bus82.sum,  8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t4_busy_rst", bus82.busy, 1'b0);
        checkOutput("t4_done_rst", bus82.done, 1'b0);
        checkOutput("t4_sum_rst",  bus82.sum,  8'h00);
        checkOutput("t4_cout_rst", bus82.cout, 1'b0);
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus82.done || bus82.busy) done_seen++;
        end
        checkOutput("t4_no_done_after", done_seen, 0);

        // 8/8: random vectors, back-to-back, inputs scrambled after accept
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
        for (int v = 0; v < 1000; v++) begin
            applyStimulus(3, 1'b1, {8'h00, ra}, {8'h00, rb}, rc);
            tick();
            rsum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            applyStimulus(3, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            tick();
            checkOutput("t5_result", {bus88.done, bus88.cout, bus88.sum}, {1'b1, rsum});
`ifdef RCA_SIGNED_OVF_EN
            checkOutput("t5_ovf", bus88.ovf, (ra[7] == rb[7]) && (rsum[7] != ra[7]));
`endif
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
        end
        applyStimulus(3, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("t5_idle_busy", bus88.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
